// File: rtl/usr_shift_ctrl_if.sv
// usr_shift_ctrl_if: command handshake plus usr drive/feedback bundle for usr_shift_ctrl
//  master: command issuer / usr side (drives cmd_*, q_fb)
//  slave : controller side (drives cmd_ready, mode, par_in, s_left, s_right, busy, done)
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_rot;
  logic             cmd_fill;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             s_left;
  logic             s_right;
  logic             busy;
  logic             done;
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_rot, cmd_fill, q_fb,
    input  cmd_ready, mode, par_in, s_left, s_right, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_rot, cmd_fill, q_fb,
    output cmd_ready, mode, par_in, s_left, s_right, busy, done
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: command sequencer driving a 4-bit universal shift register
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of usr_shift_ctrl_if (command handshake in, usr mode/par_in/serial out,
//             usr Q feedback in, busy/done status out)
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst,
  usr_shift_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d, mode_q, mode_d;
  logic             rot_q, rot_d, fill_q, fill_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             ready, xfer;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mode_q  <= '0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
      par_q   <= par_d;
    end
  end
  always_comb begin
    ready   = state_q == IDLE && !rst;
    xfer    = bus.cmd_valid && ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rot_d   = rot_q;
    fill_d  = fill_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (xfer) begin
        op_d   = bus.cmd_op;
        rot_d  = bus.cmd_rot;
        fill_d = bus.cmd_fill;
        if (bus.cmd_op == 2'b11) begin
          par_d   = bus.cmd_data;
          state_d = LOAD;
        end else begin
          cnt_d   = bus.cmd_count;
          state_d = bus.cmd_count == '0 ? DONE : RUN;
        end
      end
      LOAD: state_d = DONE;
      // count is never 0 in RUN, so leaving on 1 yields exactly cmd_count RUN cycles
      RUN: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CNT_W'(1) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    // mode is registered from the next state so it lines up with the state it describes
    mode_d = state_d == LOAD ? 2'b11 : state_d == RUN ? op_d : 2'b00;
  end
  always_comb begin
    bus.cmd_ready = ready;
    bus.busy      = state_q != IDLE;
    bus.done      = state_q == DONE;
    bus.mode      = mode_q;
    bus.par_in    = par_q;
    bus.s_right   = mode_q == 2'b01 && (rot_q ? bus.q_fb[0] : fill_q);
    bus.s_left    = mode_q == 2'b10 && (rot_q ? bus.q_fb[WIDTH-1] : fill_q);
  end
endmodule

// File: tb/tb_usr_shift_ctrl.sv
// tb_usr_shift_ctrl: table-driven scoreboard bench for usr_shift_ctrl with a behavioural usr
module tb_usr_shift_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] q = 4'b0000;
  logic [3:0] exp_q = 4'b0000;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct packed {
    logic [1:0] mode;
    logic       done;
    logic       busy;
    logic       ready;
    logic [3:0] q;
  } exp_t;
  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] cnt;
    logic       rot;
    logic       fill;
    logic [3:0] final_q;
  } vec_t;
  exp_t sb[$];
  vec_t tv[10];
  usr_shift_ctrl_if #(.WIDTH(4), .CNT_W(4)) bus ();
  usr_shift_ctrl #(.WIDTH(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk)
    case (bus.mode)
      2'b01: q <= {bus.s_right, q[3:1]};
      2'b10: q <= {q[2:0], bus.s_left};
      2'b11: q <= bus.par_in;
      default: q <= q;
    endcase
  assign bus.q_fb = q;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [3:0] nxt(input logic [1:0] op, input logic [3:0] v, input logic rot, input logic fill);
    return op == 2'b01 ? {rot ? v[0] : fill, v[3:1]} :
           op == 2'b10 ? {v[2:0], rot ? v[3] : fill} : v;
  endfunction
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt,
                         input logic rot, input logic fill, input bit hold_v);
    int w = 0;
    exp_t e;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.cmd_rot   = rot;
    bus.cmd_fill  = fill;
    if (op == 2'b11) begin
      sb.push_back('{2'b11, 1'b0, 1'b1, 1'b0, exp_q});
      exp_q = data;
      sb.push_back('{2'b00, 1'b1, 1'b1, 1'b0, exp_q});
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        sb.push_back('{op, 1'b0, 1'b1, 1'b0, exp_q});
        exp_q = nxt(op, exp_q, rot, fill);
      end
      sb.push_back('{2'b00, 1'b1, 1'b1, 1'b0, exp_q});
    end
    sb.push_back('{2'b00, 1'b0, 1'b0, 1'b1, exp_q});
    @(posedge clk);
    #1;
    if (hold_v) begin
      bus.cmd_op   = 2'b11;
      bus.cmd_data = 4'b0000;
    end else bus.cmd_valid = 1'b0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk("mode", bus.mode, e.mode);
      chk("done", bus.done, e.done);
      chk("busy", bus.busy, e.busy);
      chk("cmd_ready", bus.cmd_ready, e.ready);
      chk("q", q, e.q);
      if (e.done) bus.cmd_valid = 1'b0;
    end
  endtask
  initial begin
    tv[0] = '{2'b11, 4'b1010, 4'd0,  1'b0, 1'b0, 4'b1010};
    tv[1] = '{2'b01, 4'b0000, 4'd2,  1'b0, 1'b1, 4'b1110};
    tv[2] = '{2'b11, 4'b1010, 4'd5,  1'b1, 1'b0, 4'b1010};
    tv[3] = '{2'b10, 4'b1111, 4'd4,  1'b1, 1'b0, 4'b1010};
    tv[4] = '{2'b01, 4'b0000, 4'd0,  1'b0, 1'b1, 4'b1010};
    tv[5] = '{2'b00, 4'b0000, 4'd3,  1'b0, 1'b1, 4'b1010};
    tv[6] = '{2'b11, 4'b0110, 4'd0,  1'b0, 1'b0, 4'b0110};
    tv[7] = '{2'b01, 4'b0000, 4'd15, 1'b1, 1'b0, 4'b1100};
    tv[8] = '{2'b10, 4'b0000, 4'd3,  1'b0, 1'b0, 4'b0000};
    tv[9] = '{2'b11, 4'b1111, 4'd0,  1'b0, 1'b0, 4'b1111};
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_data  = 4'b1111;
    bus.cmd_count = 4'd0;
    bus.cmd_rot   = 1'b0;
    bus.cmd_fill  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode", bus.mode, 2'b00);
    chk("rst_par_in", bus.par_in, 4'b0000);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_q", q, 4'b0000);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.cmd_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      run_cmd(tv[i].op, tv[i].data, tv[i].cnt, tv[i].rot, tv[i].fill, 1'b0);
      chk("final_q", q, tv[i].final_q);
      if (tv[i].op == 2'b11) chk("par_in", bus.par_in, tv[i].data);
    end
    // command valid held through busy, with a load presented, must not be taken
    run_cmd(2'b01, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
    run_cmd(2'b00, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("par_in_kept", bus.par_in, 4'b1111);
    chk("q_kept", q, 4'b1111);
    // reset in the middle of a long shift aborts it
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_count = 4'd8;
    bus.cmd_rot   = 1'b0;
    bus.cmd_fill  = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("abort_mode_run", bus.mode, 2'b01);
    end
    chk("abort_q_pre", q, 4'b0001);
    rst = 1'b1;
    #1;
    chk("abort_mode", bus.mode, 2'b00);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_done", bus.done, 0);
      chk("post_abort_mode", bus.mode, 2'b00);
      chk("post_abort_q", q, 4'b0001);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
